regfile4_onehot: RTL



---
 rtl/regfile4_onehot_pkg.sv | 23 ++
 rtl/regfile4_onehot_if.sv | 29 ++
 rtl/regfile4_onehot_onehot_check.sv | 25 ++
 rtl/regfile4_onehot.sv | 106 ++++++++++
 4 files changed

// File: rtl/regfile4_onehot_pkg.sv
// regfile_pkg: shared constants, FSM state type and select-legality helper
// for the 4-entry one-hot-selected register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned ADDR_W   = 2;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // True iff exactly one select bit is set.
    function automatic logic onehot_ok(input logic [0:NUM_REGS-1] sel);
        logic [2:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) cnt = cnt + 3'd1;
        end
        return (cnt == 3'd1);
    endfunction

endpackage

// File: rtl/regfile4_onehot_if.sv
// regfile4_onehot_if: write handshake, two read ports and clear control
// of the register file. master = requester side, slave = register file.
interface regfile4_onehot_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic                    wr_valid;
    logic [0:NUM_REGS-1]     wr_sel;
    logic [WIDTH-1:0]        wr_data;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       rd_addr_a;
    logic [ADDR_W-1:0]       rd_addr_b;
    logic [WIDTH-1:0]        rd_data_a;
    logic [WIDTH-1:0]        rd_data_b;
    logic                    clr_req;
    logic                    clr_busy;
    logic                    sel_err;

    modport master (
        output wr_valid, wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
        input  wr_ready, rd_data_a, rd_data_b, clr_busy, sel_err
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
        output wr_ready, rd_data_a, rd_data_b, clr_busy, sel_err
    );
endinterface

// File: rtl/regfile4_onehot_onehot_check.sv
// onehot_check: combinational legality of the write select plus the sticky
// sel_err flag, which only reset clears.
module onehot_check
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                check,
    input  logic [0:NUM_REGS-1] sel,
    output logic                legal,
    output logic                sel_err
);

    assign legal = onehot_ok(sel);

    // Latch any accepted write whose select is not one-hot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (check && !legal) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile4_onehot.sv
// regfile4_onehot: 4 x WIDTH register file written through a one-hot select,
// two registered read ports and a 4-cycle sequenced clear.
// Optional macro REGFILE4_BYPASS_EN: forward same-cycle legal write data to
// a read port addressing the written register.
module regfile4_onehot
    import regfile_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
)(
    input logic               clk,
    input logic               rst_n,
    regfile4_onehot_if.slave  bus
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic                wr_ready, clr_busy;
    logic                wr_accept, wr_legal, sel_err;
    logic [0:NUM_REGS-1] wr_en;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [WIDTH-1:0]    rd_nxt_a, rd_nxt_b;

    assign bus.wr_ready = wr_ready;
    assign bus.clr_busy = clr_busy;
    assign bus.sel_err  = sel_err;

    assign wr_accept = bus.wr_valid & wr_ready;
    assign wr_en     = (wr_accept && wr_legal) ? bus.wr_sel : '0;

    onehot_check u_onehot_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .check   (wr_accept),
        .sel     (bus.wr_sel),
        .legal   (wr_legal),
        .sel_err (sel_err)
    );

    // Clear sequencer state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state and handshake outputs; clr_req during CLEAR is ignored.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_ready    = 1'b0;
        clr_busy    = 1'b0;
        case (state)
            IDLE: begin
                wr_ready    = 1'b1;
                clr_cnt_nxt = '0;
                if (bus.clr_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_busy    = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage: writes only happen in IDLE, clears only in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= CLR_VALUE;
        end else begin
            if (clr_busy) regs[clr_cnt] <= CLR_VALUE;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) regs[i] <= bus.wr_data;
            end
        end
    end

    // Read-port next values, with optional write-through forwarding.
    always_comb begin
        rd_nxt_a = regs[bus.rd_addr_a];
        rd_nxt_b = regs[bus.rd_addr_b];
`ifdef REGFILE4_BYPASS_EN
        if (wr_en[bus.rd_addr_a]) rd_nxt_a = bus.wr_data;
        if (wr_en[bus.rd_addr_b]) rd_nxt_b = bus.wr_data;
`else
`endif
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data_a <= CLR_VALUE;
            bus.rd_data_b <= CLR_VALUE;
        end else begin
            bus.rd_data_a <= rd_nxt_a;
            bus.rd_data_b <= rd_nxt_b;
        end
    end

endmodule
